// File: rtl/alu_cmp_pkg.sv
// Shared definitions for the serial magnitude comparator.
//   state_e    : comparator FSM states (IDLE, SCAN).
//   cmp_res_e  : three-way compare result code.
//   WIDTH_DEF / BPC_DEF / NCHUNK : default geometry (32-bit operands, 2 bits per cycle).
//   idx_bits() : width of a counter that indexes n chunks (never below 1).
package alu_cmp_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int BPC_DEF   = 2;
    localparam int NCHUNK    = WIDTH_DEF / BPC_DEF;

    typedef enum logic {
        IDLE,
        SCAN
    } state_e;

    typedef enum logic [1:0] {
        CMP_LT,
        CMP_EQ,
        CMP_GT
    } cmp_res_e;

    function automatic int idx_bits(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/chunk_cmp.sv
// Combinational BPC-bit chunk comparator.
// Ports:
//   a_chunk, b_chunk : chunk of operand A / B (MSB of the chunk is bit BPC-1).
//   sign_override    : set on the top chunk of a signed compare; when the chunk
//                      MSBs (operand sign bits) differ, the negative operand wins
//                      as the smaller one regardless of the other bits.
//   chunk_gt/lt      : A chunk greater / less than B chunk (both 0 when equal).
module chunk_cmp #(
    parameter int BPC = 2
) (
    input  logic [BPC-1:0] a_chunk,
    input  logic [BPC-1:0] b_chunk,
    input  logic           sign_override,
    output logic           chunk_gt,
    output logic           chunk_lt
);

    always_comb begin
        chunk_gt = 1'b0;
        chunk_lt = 1'b0;
        if (sign_override && (a_chunk[BPC-1] != b_chunk[BPC-1])) begin
            // Sign bit set means negative, hence smaller.
            chunk_lt = a_chunk[BPC-1];
            chunk_gt = b_chunk[BPC-1];
        end else begin
            // Same sign (or unsigned): plain magnitude compare is correct.
            chunk_gt = (a_chunk > b_chunk);
            chunk_lt = (a_chunk < b_chunk);
        end
    end

endmodule

// File: rtl/serial_gt_compare.sv
// Multi-cycle magnitude comparator. Operands are latched on start and scanned
// MSB-first, BPC bits per cycle; the scan stops at the first differing chunk
// or after the last chunk.
// Ports:
//   clk        : rising-edge clock.
//   rst_n      : synchronous active-low reset.
//   start      : compare request, accepted only in IDLE.
//   is_signed  : two's-complement interpretation, latched with start.
//   a, b       : operands, latched with start.
//   busy       : high while scanning.
//   done       : one-cycle pulse when gt/lt/eq are written.
//   gt, lt, eq : result, held until the next decision.
// WIDTH must be a multiple of BPC; BPC is 1, 2 or 4.
module serial_gt_compare
    import alu_cmp_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int BPC   = BPC_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             is_signed,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             lt,
    output logic             eq
);

    localparam int NCH   = WIDTH / BPC;
    localparam int IDX_W = idx_bits(NCH);
    localparam logic [IDX_W-1:0] TOP_IDX = IDX_W'(NCH - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             signed_q, signed_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic             done_q, done_d;
    logic             gt_q, gt_d;
    logic             lt_q, lt_d;
    logic             eq_q, eq_d;

    // Latched operands split into chunks so the scan is a simple array select.
    logic [BPC-1:0] a_chunks [NCH];
    logic [BPC-1:0] b_chunks [NCH];

    for (genvar gi = 0; gi < NCH; gi++) begin : g_chunks
        assign a_chunks[gi] = a_q[gi*BPC +: BPC];
        assign b_chunks[gi] = b_q[gi*BPC +: BPC];
    end

    logic     chunk_gt;
    logic     chunk_lt;
    logic     sign_override;
    cmp_res_e res;

    // The sign rule only matters on the chunk holding the operand sign bits.
    assign sign_override = signed_q && (idx_q == TOP_IDX);

    chunk_cmp #(
        .BPC (BPC)
    ) u_chunk_cmp (
        .a_chunk       (a_chunks[idx_q]),
        .b_chunk       (b_chunks[idx_q]),
        .sign_override (sign_override),
        .chunk_gt      (chunk_gt),
        .chunk_lt      (chunk_lt)
    );

    always_comb begin
        if (chunk_gt) begin
            res = CMP_GT;
        end else if (chunk_lt) begin
            res = CMP_LT;
        end else begin
            res = CMP_EQ;
        end
    end

    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        signed_d = signed_q;
        idx_d    = idx_q;
        done_d   = 1'b0;
        gt_d     = gt_q;
        lt_d     = lt_q;
        eq_d     = eq_q;
        case (state_q)
            IDLE: begin
                // Results are intentionally left alone here; they persist
                // until the next decision.
                if (start) begin
                    a_d      = a;
                    b_d      = b;
                    signed_d = is_signed;
                    idx_d    = TOP_IDX;
                    state_d  = SCAN;
                end
            end
            SCAN: begin
                if ((res != CMP_EQ) || (idx_q == '0)) begin
                    gt_d    = (res == CMP_GT);
                    lt_d    = (res == CMP_LT);
                    eq_d    = (res == CMP_EQ);
                    done_d  = 1'b1;
                    state_d = IDLE;
                end else begin
                    idx_d = idx_q - IDX_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            signed_q <= 1'b0;
            idx_q    <= '0;
            done_q   <= 1'b0;
            gt_q     <= 1'b0;
            lt_q     <= 1'b0;
            eq_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            signed_q <= signed_d;
            idx_q    <= idx_d;
            done_q   <= done_d;
            gt_q     <= gt_d;
            lt_q     <= lt_d;
            eq_q     <= eq_d;
        end
    end

    assign busy = (state_q == SCAN);
    assign done = done_q;
    assign gt   = gt_q;
    assign lt   = lt_q;
    assign eq   = eq_q;

endmodule

// File: tb/tb_serial_gt_compare.sv
// Scoreboard bench for serial_gt_compare: the driver pushes the expected
// result and completion cycle of every accepted compare; the monitor checks
// busy, done timing, result and result hold on every falling edge.
module tb_serial_gt_compare;

    localparam int WIDTH = 32;
    localparam int BPC   = 2;
    localparam int NCH   = WIDTH / BPC;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             is_signed = 1'b0;
    logic [WIDTH-1:0] a = '0;
    logic [WIDTH-1:0] b = '0;
    logic             busy, done, gt, lt, eq;

    serial_gt_compare #(
        .WIDTH (WIDTH),
        .BPC   (BPC)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .is_signed (is_signed),
        .a         (a),
        .b         (b),
        .busy      (busy),
        .done      (done),
        .gt        (gt),
        .lt        (lt),
        .eq        (eq)
    );

    always #5 clk = ~clk;

    typedef struct {
        int   t;      // edge where start is sampled
        int   dc;     // edge where done is written
        logic g;
        logic l;
        logic e;
    } exp_t;

    exp_t sb[$];
    int   cyc = 0;
    logic rst_at_edge = 1'b0;
    int   tests = 0;
    int   fails = 0;
    logic [2:0] last_res = 3'b000;

    // Edge counter and the reset level seen by the DUT at that edge.
    initial begin
        forever begin
            @(posedge clk);
            cyc++;
            rst_at_edge = rst_n;
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h required %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Reference: signed/unsigned ordering by plain arithmetic; latency from
    // the position of the most significant differing bit.
    function automatic exp_t model(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                                   input logic s, input int t);
        exp_t e;
        logic [WIDTH-1:0] d;
        int lat;
        logic found;
        d = av ^ bv;
        lat = NCH;
        found = 1'b0;
        for (int k = WIDTH - 1; k >= 0; k--) begin
            if (!found && d[k]) begin
                lat = NCH - k / BPC;
                found = 1'b1;
            end
        end
        if (s) begin
            e.g = ($signed(av) > $signed(bv));
            e.l = ($signed(av) < $signed(bv));
        end else begin
            e.g = (av > bv);
            e.l = (av < bv);
        end
        e.e = (av == bv);
        e.t = t;
        e.dc = t + lat;
        return e;
    endfunction

    // Monitor
    initial begin
        exp_t e;
        logic exp_busy;
        @(posedge clk);
        forever begin
            @(negedge clk);
            if (!rst_at_edge) begin
                sb.delete();
                last_res = 3'b000;
                chk("rst_busy", {31'd0, busy}, 32'd0);
                chk("rst_done", {31'd0, done}, 32'd0);
                chk("rst_result", {29'd0, gt, lt, eq}, 32'd0);
            end else begin
                exp_busy = (sb.size() > 0) && (cyc >= sb[0].t) && (cyc < sb[0].dc);
                chk("busy", {31'd0, busy}, {31'd0, exp_busy});
                if (done) begin
                    if (sb.size() == 0) begin
                        chk("spurious_done", {31'd0, done}, 32'd0);
                    end else begin
                        e = sb.pop_front();
                        chk("done_cycle", cyc, e.dc);
                        chk("result", {29'd0, gt, lt, eq}, {29'd0, e.g, e.l, e.e});
                        last_res = {e.g, e.l, e.e};
                        $display("[TB] cmp done cycle %0d gt=%0b lt=%0b eq=%0b", cyc, gt, lt, eq);
                    end
                end else begin
                    if ((sb.size() > 0) && (cyc >= sb[0].dc)) begin
                        chk("done_timeout", {31'd0, done}, 32'd1);
                        void'(sb.pop_front());
                    end
                    chk("hold", {29'd0, gt, lt, eq}, {29'd0, last_res});
                end
            end
        end
    end

    // Called at posedge+1; leaves the bench at posedge+1.
    task automatic issue(input logic [WIDTH-1:0] av, input logic [WIDTH-1:0] bv,
                         input logic s, input int junk);
        int n;
        int j;
        exp_t e;
        n = 0;
        while (busy && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (busy) chk("idle_wait", {31'd0, busy}, 32'd0);
        a = av;
        b = bv;
        is_signed = s;
        start = 1'b1;
        e = model(av, bv, s, cyc + 1);
        sb.push_back(e);
        $display("[TB] issue a=%08h b=%08h signed=%0b at edge %0d", av, bv, s, cyc + 1);
        @(posedge clk);
        #1;
        start = 1'b0;
        // Requests and operand changes while scanning must be ignored; stop
        // before the decision edge so nothing lands in IDLE.
        j = junk;
        if (j > e.dc - e.t - 1) j = e.dc - e.t - 1;
        for (int k = 0; k < j; k++) begin
            start = 1'b1;
            a = $urandom;
            b = $urandom;
            is_signed = 1'($urandom_range(0, 1));
            @(posedge clk);
            #1;
        end
        start = 1'b0;
    endtask

    initial begin
        logic [WIDTH-1:0] ra;
        logic [WIDTH-1:0] rb;
        int mode;
        int k;

        // Reset held with start asserted: nothing may start.
        rst_n = 1'b0;
        start = 1'b1;
        a = 32'h0000_0005;
        b = 32'h0000_0003;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        issue(32'h8000_0000, 32'h7FFF_FFFF, 1'b0, 0);
        issue(32'h8000_0000, 32'h7FFF_FFFF, 1'b1, 0);
        issue(32'h1234_5678, 32'h1234_5678, 1'b0, 0);
        issue(32'h0000_0001, 32'h0000_0003, 1'b0, 0);
        issue(32'h0000_0005, 32'h0000_0005, 1'b0, 0);   // back-to-back in done cycle
        issue(32'hFFFF_FFFF, 32'h0000_0001, 1'b1, 3);   // ignored starts mid-scan
        issue(32'h0000_0100, 32'h0000_0200, 1'b0, 4);
        issue(32'hFFFF_FFFE, 32'hFFFF_FFFF, 1'b1, 2);

        // Abort at SCAN cycle 5 with a nonzero prior result.
        issue(32'hCAFE_F00D, 32'hCAFE_F00D, 1'b0, 0);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        for (int i = 0; i < 150; i++) begin
            ra = $urandom;
            mode = $urandom_range(0, 3);
            k = $urandom_range(0, WIDTH - 1);
            case (mode)
                0: rb = $urandom;
                1: rb = ra;
                2: rb = ra ^ (32'h1 << k);
                default: rb = {~ra[WIDTH-1], ra[WIDTH-2:0]} ^ ({31'd0, 1'b1} << k);
            endcase
            issue(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end

        k = 0;
        while (sb.size() > 0 && k < 40) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("drain", sb.size(), 32'd0);
        repeat (2) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
